// File: rtl/imem_arb_pkg.sv
// Shared widths and enumerations for the instruction-memory arbiter.
// The FSM and read-owner encodings are kept here so the bench and RTL agree.
package imem_arb_pkg;

  localparam int IMEM_AW  = 11;
  localparam int IMEM_DW  = 32;
  localparam int WR_CNT_W = 12;

  // Loader write counter stops here instead of wrapping.
  localparam logic [WR_CNT_W-1:0] WR_CNT_MAX = 12'd2048;

  typedef enum logic [1:0] {
    HALT,
    RUN,
    DRAIN
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_LD
  } owner_t;

endpackage

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between the CPU fetch stage and a loader/debug port.
// A HALT/RUN/DRAIN FSM gates fetch access; the loader wins ties unless it won the previous cycle.
module imem_arbiter
  import imem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               run_req,
  input  logic               halt_req,
  input  logic               fetch_req,
  input  logic [IMEM_AW-1:0] fetch_addr,
  output logic               fetch_gnt,
  output logic               fetch_rvalid,
  output logic               pc_write_en,
  input  logic               ld_req,
  input  logic               ld_wr,
  input  logic [IMEM_AW-1:0] ld_addr,
  input  logic [IMEM_DW-1:0] ld_wdata,
  output logic               ld_gnt,
  output logic               ld_rvalid,
  output logic [IMEM_AW-1:0] mem_addr,
  output logic [IMEM_DW-1:0] mem_data,
  output logic               mem_rden,
  output logic               mem_wren,
  input  logic [IMEM_DW-1:0] mem_q,
  output logic               cpu_run,
  output logic [WR_CNT_W-1:0] ld_wr_count
);

  arb_state_t          state_q, state_d;
  logic                last_ld_q, last_ld_d;
  logic                rd_pending_q, rd_pending_d;
  owner_t              rd_owner_q, rd_owner_d;
  logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  logic fetch_win;
  logic ld_win;
  logic unused_mem_q;

  // Read data goes straight to the requesters; only the rvalid strobes come from here.
  assign unused_mem_q = ^mem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HALT;
      last_ld_q    <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= OWN_FETCH;
      wr_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_ld_q    <= last_ld_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  // A grant raised in the last RUN cycle is still honoured; DRAIN lets its data return.
  always_comb begin
    state_d   = state_q;
    fetch_win = 1'b0;
    ld_win    = 1'b0;
    unique case (state_q)
      HALT: begin
        ld_win = ld_req;
        if (run_req) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (fetch_req && ld_req) begin
          ld_win    = !last_ld_q;
          fetch_win = last_ld_q;
        end else begin
          ld_win    = ld_req;
          fetch_win = fetch_req;
        end
        if (halt_req) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // Grants are forced low while reset is held, even though the loader could win in HALT.
  assign ld_gnt      = ld_win & rst;
  assign fetch_gnt   = fetch_win & rst;
  assign pc_write_en = fetch_gnt;
  assign cpu_run     = (state_q == RUN);

  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_rden = 1'b0;
    mem_wren = 1'b0;
    if (ld_gnt) begin
      mem_addr = ld_addr;
      if (ld_wr) begin
        mem_wren = 1'b1;
        mem_data = ld_wdata;
      end else begin
        mem_rden = 1'b1;
      end
    end else if (fetch_gnt) begin
      mem_addr = fetch_addr;
      mem_rden = 1'b1;
    end
  end

  always_comb begin
    rd_pending_d = mem_rden;
    rd_owner_d   = rd_owner_q;
    if (fetch_gnt) begin
      rd_owner_d = OWN_FETCH;
    end else if (ld_gnt && !ld_wr) begin
      rd_owner_d = OWN_LD;
    end
    last_ld_d = ld_gnt;
    wr_cnt_d  = wr_cnt_q;
    if (mem_wren && (wr_cnt_q != WR_CNT_MAX)) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  assign fetch_rvalid = rd_pending_q && (rd_owner_q == OWN_FETCH);
  assign ld_rvalid    = rd_pending_q && (rd_owner_q == OWN_LD);
  assign ld_wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized and directed bench for imem_arbiter, checked every cycle against
// a behavioural model of the arbitration rules plus a reference memory image.
module tb_imem_arbiter;
   import imem_arb_pkg::*;

   localparam int M_HALT  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run_req = 1'b0;
   logic        halt_req = 1'b0;
   logic        fetch_req = 1'b0;
   logic [10:0] fetch_addr = '0;
   logic        fetch_gnt;
   logic        fetch_rvalid;
   logic        pc_write_en;
   logic        ld_req = 1'b0;
   logic        ld_wr = 1'b0;
   logic [10:0] ld_addr = '0;
   logic [31:0] ld_wdata = '0;
   logic        ld_gnt;
   logic        ld_rvalid;
   logic [10:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_rden;
   logic        mem_wren;
   logic [31:0] mem_q = '0;
   logic        cpu_run;
   logic [11:0] ld_wr_count;

   logic [31:0] tbMem  [0:2047] = '{default: '0};
   logic [31:0] refMem [0:2047] = '{default: '0};

   int checks = 0;
   int failures = 0;

   int          mMode;
   bit          mLastLd;
   bit          mPend;
   bit          mPendFetch;
   logic [31:0] mPendData;
   int          mCount;

   bit          eFetchGnt, eLdGnt, eRden, eWren;
   logic [10:0] eAddr;
   logic [31:0] eData;

   bit          oFetchGnt, oLdGnt, oWren, oRvF, oRvL, oCpuRun;
   logic [10:0] oAddr;
   logic [31:0] oMemQ;
   logic [11:0] oCount;

   imem_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .run_req      (run_req),
      .halt_req     (halt_req),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_gnt    (fetch_gnt),
      .fetch_rvalid (fetch_rvalid),
      .pc_write_en  (pc_write_en),
      .ld_req       (ld_req),
      .ld_wr        (ld_wr),
      .ld_addr      (ld_addr),
      .ld_wdata     (ld_wdata),
      .ld_gnt       (ld_gnt),
      .ld_rvalid    (ld_rvalid),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .mem_rden     (mem_rden),
      .mem_wren     (mem_wren),
      .mem_q        (mem_q),
      .cpu_run      (cpu_run),
      .ld_wr_count  (ld_wr_count)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM standing in for the instruction memory.
   always @(posedge clk) begin
      if (mem_wren) tbMem[mem_addr] <= mem_data;
      if (mem_rden) mem_q <= tbMem[mem_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      mMode   = M_HALT;
      mLastLd = 1'b0;
      mPend   = 1'b0;
      mPendFetch = 1'b0;
      mCount  = 0;
   endtask

   // Loader has priority, except that it yields to a waiting fetch right after its own grant.
   task automatic predict();
      eFetchGnt = 1'b0;
      eLdGnt    = 1'b0;
      if (rst) begin
         if (mMode == M_HALT) begin
            eLdGnt = ld_req;
         end else if (mMode == M_RUN) begin
            if (ld_req && !(fetch_req && mLastLd)) eLdGnt = 1'b1;
            else if (fetch_req) eFetchGnt = 1'b1;
         end
      end
      eRden = eFetchGnt || (eLdGnt && !ld_wr);
      eWren = eLdGnt && ld_wr;
      eAddr = eLdGnt ? ld_addr : (eFetchGnt ? fetch_addr : 11'd0);
      eData = eWren ? ld_wdata : 32'd0;
   endtask

   task automatic compareAll(input string tag);
      oFetchGnt = fetch_gnt;
      oLdGnt    = ld_gnt;
      oWren     = mem_wren;
      oRvF      = fetch_rvalid;
      oRvL      = ld_rvalid;
      oCpuRun   = cpu_run;
      oAddr     = mem_addr;
      oMemQ     = mem_q;
      oCount    = ld_wr_count;
      checkOutput({tag, ".fetch_gnt"},    32'(fetch_gnt),    32'(eFetchGnt));
      checkOutput({tag, ".pc_write_en"},  32'(pc_write_en),  32'(eFetchGnt));
      checkOutput({tag, ".ld_gnt"},       32'(ld_gnt),       32'(eLdGnt));
      checkOutput({tag, ".mem_addr"},     32'(mem_addr),     32'(eAddr));
      checkOutput({tag, ".mem_data"},     mem_data,          eData);
      checkOutput({tag, ".mem_rden"},     32'(mem_rden),     32'(eRden));
      checkOutput({tag, ".mem_wren"},     32'(mem_wren),     32'(eWren));
      checkOutput({tag, ".cpu_run"},      32'(cpu_run),      32'(mMode == M_RUN));
      checkOutput({tag, ".fetch_rvalid"}, 32'(fetch_rvalid), 32'(mPend && mPendFetch));
      checkOutput({tag, ".ld_rvalid"},    32'(ld_rvalid),    32'(mPend && !mPendFetch));
      checkOutput({tag, ".ld_wr_count"},  32'(ld_wr_count),  32'(mCount));
      if (mPend) checkOutput({tag, ".mem_q"}, mem_q, mPendData);
   endtask

   task automatic updateModel();
      if (eRden) begin
         mPend      = 1'b1;
         mPendFetch = eFetchGnt;
         mPendData  = refMem[eAddr];
      end else begin
         mPend = 1'b0;
      end
      if (eWren) begin
         refMem[eAddr] = eData;
         if (mCount < 2048) mCount++;
      end
      mLastLd = eLdGnt;
      case (mMode)
         M_HALT:  if (run_req) mMode = M_RUN;
         M_RUN:   if (halt_req) mMode = M_DRAIN;
         default: mMode = M_HALT;
      endcase
   endtask

   // Drives one cycle of inputs between edges, checks outputs, then advances model across the edge.
   task automatic applyStimulus(input bit runP, input bit haltP, input bit fReq, input logic [10:0] fAddr,
                                input bit lReq, input bit lWr, input logic [10:0] lAddr,
                                input logic [31:0] lData, input string tag);
      run_req    = runP;
      halt_req   = haltP;
      fetch_req  = fReq;
      fetch_addr = fAddr;
      ld_req     = lReq;
      ld_wr      = lWr;
      ld_addr    = lAddr;
      ld_wdata   = lData;
      #1;
      predict();
      compareAll(tag);
      @(posedge clk);
      updateModel();
      @(negedge clk);
   endtask

   task automatic idle(input string tag);
      applyStimulus(1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, tag);
   endtask

   // Requests stay high during reset so any ungated grant would show up.
   task automatic doReset(input string tag);
      rst       = 1'b0;
      run_req   = 1'b0;
      halt_req  = 1'b0;
      fetch_req = 1'b1;
      ld_req    = 1'b1;
      ld_wr     = 1'b1;
      ld_addr   = 11'd3;
      ld_wdata  = 32'h1234_5678;
      resetModel();
      #1;
      predict();
      compareAll(tag);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      predict();
      compareAll({tag, "_hold"});
      rst       = 1'b1;
      fetch_req = 1'b0;
      ld_req    = 1'b0;
      ld_wr     = 1'b0;
   endtask

   // Halt, then two quiet cycles, lands in HALT from any state.
   task automatic goHalt();
      applyStimulus(1'b0, 1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, "gohalt");
      idle("gohalt_idle0");
      idle("gohalt_idle1");
   endtask

   initial begin
      bit runP, haltP;
      int r;

      #2;
      doReset("reset");

      applyStimulus(1'b0, 1'b0, 1'b1, 11'd5, 1'b1, 1'b1, 11'd5, 32'hDEAD_BEEF, "r39");
      checkOutput("r39_wren", 32'(oWren), 32'd1);
      checkOutput("r39_addr", 32'(oAddr), 32'd5);
      checkOutput("r39_fetch_gnt", 32'(oFetchGnt), 32'd0);
      idle("r39_after");
      checkOutput("r39_count", 32'(oCount), 32'd1);

      applyStimulus(1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, "r40_run");
      applyStimulus(1'b0, 1'b0, 1'b1, 11'd5, 1'b0, 1'b0, 11'd0, 32'd0, "r40_fetch");
      checkOutput("r40_fetch_gnt", 32'(oFetchGnt), 32'd1);
      checkOutput("r40_cpu_run", 32'(oCpuRun), 32'd1);
      idle("r40_data");
      checkOutput("r40_rvalid", 32'(oRvF), 32'd1);
      checkOutput("r40_mem_q", oMemQ, 32'hDEAD_BEEF);

      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 11'(k), 1'b1, 1'b0, 11'(k + 8), 32'd0, "r41");
         checkOutput($sformatf("r41_ld_%0d", k), 32'(oLdGnt), 32'((k % 2) == 0));
         checkOutput($sformatf("r41_fetch_%0d", k), 32'(oFetchGnt), 32'((k % 2) == 1));
      end

      applyStimulus(1'b1, 1'b1, 1'b1, 11'd5, 1'b0, 1'b0, 11'd0, 32'd0, "r42");
      checkOutput("r42_fetch_honoured", 32'(oFetchGnt), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 11'd5, 1'b1, 1'b1, 11'd9, 32'h0BAD_0BAD, "r42_drain");
      checkOutput("r42_drain_cpu_run", 32'(oCpuRun), 32'd0);
      checkOutput("r42_drain_no_ld", 32'(oLdGnt), 32'd0);
      checkOutput("r42_drain_rvalid", 32'(oRvF), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 11'd5, 1'b1, 1'b1, 11'd9, 32'h0BAD_0BAD, "r42_halt");
      checkOutput("r42_halt_cpu_run", 32'(oCpuRun), 32'd0);
      checkOutput("r42_halt_ld", 32'(oLdGnt), 32'd1);
      checkOutput("r42_halt_no_fetch", 32'(oFetchGnt), 32'd0);

      // Small address window so reads frequently hit earlier writes.
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 31));
         runP  = (r < 2);
         haltP = (r == 2);
         applyStimulus(runP, haltP, 1'($urandom), 11'($urandom_range(0, 15)),
                       1'($urandom), 1'($urandom), 11'($urandom_range(0, 15)), $urandom, "rand");
      end

      goHalt();
      for (int i = 0; i < 2050; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 11'($urandom_range(0, 15)), $urandom, "r43");
      end
      idle("r43_done");
      checkOutput("r43_saturated", 32'(oCount), 32'd2048);

      goHalt();
      applyStimulus(1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'd0, "r44_run");
      applyStimulus(1'b0, 1'b0, 1'b1, 11'd5, 1'b0, 1'b0, 11'd0, 32'd0, "r44_fetch");
      checkOutput("r44_fetch_gnt", 32'(oFetchGnt), 32'd1);
      doReset("r44_reset");
      checkOutput("r44_rst_rvalid", 32'(oRvF), 32'd0);
      checkOutput("r44_rst_count", 32'(oCount), 32'd0);
      idle("r44_release");
      checkOutput("r44_release_rvalid", 32'(oRvF), 32'd0);
      checkOutput("r44_release_cpu_run", 32'(oCpuRun), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
